// File: rtl/uart_pkg.sv
// Shared UART constants, state encoding and helpers.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned IDX_W      = $clog2(DATA_BITS);
  localparam int unsigned STATE_W    = 3;
  localparam logic        IDLE_LEVEL = 1'b1;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_e;

  // LSB-first deserialisation: shift right, new bit enters at the MSB.
  function automatic logic [DATA_BITS-1:0] shift_in(input logic [DATA_BITS-1:0] sh,
                                                    input logic                  b);
    return {b, sh[DATA_BITS-1:1]};
  endfunction

endpackage

// File: rtl/sync2.sv
// Single-bit two-flop synchronizer with a parameterised reset value.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1;

  // Metastability filter: s1 may go metastable, q_o gets a settled copy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1  <= RST_VAL;
      q_o <= RST_VAL;
    end else begin
      s1  <= d_i;
      q_o <= s1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver running directly on the system clock.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 2500,
  parameter int unsigned HALF         = CLKS_PER_BIT / 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       line_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  state_e               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 valid_n;
  logic                 ferr_n;

  logic                 s2;
  logic                 s2_q;
  logic [1:0]           sync_fill;
  logic                 armed;
  logic                 fall;

  sync2 #(
    .RST_VAL (IDLE_LEVEL)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (line_i),
    .q_o   (s2)
  );

  // Edge-detect history flop plus start-edge arming.
  // The synchronizer resets to idle, so a line held low across reset would
  // otherwise look like a falling edge; arming waits until a real high level
  // has travelled through the synchronizer before any edge is accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_q      <= IDLE_LEVEL;
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      s2_q      <= s2;
      sync_fill <= {sync_fill[0], 1'b1};
      armed     <= armed | (sync_fill[1] & s2);
    end
  end

  assign fall = armed & s2_q & ~s2;

  // State, counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      sh          <= '0;
      data_o      <= 8'h00;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      sh          <= sh_n;
      data_o      <= data_n;
      valid_o     <= valid_n;
      frame_err_o <= ferr_n;
      busy_o      <= (state_n != IDLE);
    end
  end

  // Next-state and output decode for one frame.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    data_n  = data_o;
    valid_n = 1'b0;
    ferr_n  = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (fall) begin
          state_n = START;
        end
      end

      START: begin
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_HALF) begin
          cnt_n = '0;
          if (!s2) begin
            state_n = DATA;
            idx_n   = '0;
          end else begin
            // Too short to be a start bit: treat as a glitch.
            state_n = IDLE;
          end
        end
      end

      DATA: begin
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          sh_n  = shift_in(sh, s2);
          if (idx == IDX_LAST) begin
            state_n = STOP;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end
      end

      STOP: begin
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (s2) begin
            data_n  = sh;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end
        end
      end

      BREAK: begin
        // One error per low period; resume only once the line is idle again.
        cnt_n = '0;
        if (s2) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int unsigned CPB  = 16;
  localparam int unsigned HALF = 8;
  // Pulse appears after edge 2+HALF+9*CPB, counted from the first low sample.
  localparam int          LAT  = 2 + HALF + 9 * CPB + 1;

  logic       clk;
  logic       rst_i;
  logic       line_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       busy_o;

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .HALF         (HALF)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .line_i      (line_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         t;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] model_data = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d cyc=%0d", name, got, expv, cyc);
    end
  endtask

  // Serialise one 8N1 frame; called on a falling clock edge.
  task automatic send(input logic [7:0] b, input logic stop, input int hold_low, input int gap);
    exp_t e;
    e.is_err = ~stop;
    e.data   = b;
    e.t      = cyc + LAT;
    exp_q.push_back(e);
    line_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      line_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    line_i = stop;
    repeat (CPB) @(negedge clk);
    if (!stop) begin
      line_i = 1'b0;
      repeat (hold_low) @(negedge clk);
      chk("busy_in_break", int'(busy_o), 1);
    end
    line_i = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_i && (valid_o || frame_err_o)) begin
        if (valid_o && frame_err_o) begin
          chk("both_pulses", 1, 0);
        end else if (exp_q.size() == 0) begin
          chk("unexpected_pulse", int'(valid_o) * 2 + int'(frame_err_o), 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind_ferr", int'(frame_err_o), int'(e.is_err));
          chk("pulse_time", cyc, e.t);
          if (e.is_err) begin
            chk("data_held_on_ferr", int'(data_o), int'(model_data));
          end else begin
            model_data = e.data;
            chk("data", int'(data_o), int'(e.data));
          end
        end
      end
    end
  end

  initial begin
    int c;
    logic [7:0] b81;
    rst_i  = 1'b1;
    line_i = 1'b1;
    repeat (5) @(negedge clk);
    rst_i = 1'b0;
    chk("reset_data", int'(data_o), 0);
    chk("reset_valid", int'(valid_o), 0);
    chk("reset_ferr", int'(frame_err_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    repeat (10) @(negedge clk);

    // Single good frame.
    send(8'h55, 1'b1, 0, 20);

    // Back-to-back frames, no idle gap.
    send(8'h00, 1'b1, 0, 0);
    send(8'hFF, 1'b1, 0, 0);
    send(8'hA5, 1'b1, 0, 20);

    // Short glitch must be rejected without any pulse.
    c = cyc;
    line_i = 1'b0;
    repeat (4) @(negedge clk);
    line_i = 1'b1;
    while (cyc < c + 5) @(negedge clk);
    chk("glitch_busy_high", int'(busy_o), 1);
    while (cyc < c + 12) @(negedge clk);
    chk("glitch_busy_low", int'(busy_o), 0);
    repeat (20) @(negedge clk);

    // Framing error followed by a held-low break.
    send(8'h3C, 1'b0, 40, 0);
    repeat (4) @(negedge clk);
    chk("break_busy_release", int'(busy_o), 0);
    repeat (20) @(negedge clk);

    // Reset in the middle of data bit 3 of 0x81.
    b81 = 8'h81;
    line_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      line_i = b81[i];
      repeat (CPB) @(negedge clk);
    end
    line_i = b81[3];
    repeat (5) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    chk("midrst_data", int'(data_o), 0);
    chk("midrst_valid", int'(valid_o), 0);
    chk("midrst_ferr", int'(frame_err_o), 0);
    chk("midrst_busy", int'(busy_o), 0);
    rst_i = 1'b0;
    model_data = 8'h00;
    repeat (CPB - 6) @(negedge clk);
    for (int i = 4; i < 8; i++) begin
      line_i = b81[i];
      repeat (CPB) @(negedge clk);
    end
    line_i = 1'b1;
    repeat (CPB + 20) @(negedge clk);
    chk("midrst_no_frame_busy", int'(busy_o), 0);
    send(8'h42, 1'b1, 0, 20);

    // String "HI\0" as the transmitter would send it.
    send(8'h48, 1'b1, 0, 0);
    send(8'h49, 1'b1, 0, 0);
    send(8'h00, 1'b1, 0, 20);

    // Random frames with random gaps and occasional bad stop bits.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] rb;
      logic       st;
      rb = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 7) != 0);
      if (st) send(rb, 1'b1, 0, int'($urandom_range(0, 20)));
      else    send(rb, 1'b0, int'($urandom_range(0, 30)), int'($urandom_range(4, 20)));
    end

    // Drain with a bounded wait.
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_queue_empty", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    chk("final_data", int'(data_o), int'(model_data));
    chk("final_busy", int'(busy_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
